cacheline_fifo: RTL and testbench
=================================

CACHELINE_FIFO -- requirements
Module: cacheline_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 512: cacheline width in bits.
REQ-002 SHALL have parameter DEPTH, default 256: entry count; power of 2, 4 or more.
REQ-003 SHALL have parameter BANKS, default 2: number of RAM slices DATA_W is split across; DATA_W % BANKS == 0.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-8: almost-full level.
REQ-005 SHALL have port clk  in  1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid  in  1: write request.
REQ-008 SHALL have port in_ready  out  1: the FIFO can accept a write.
REQ-009 SHALL have port in_data  in  DATA_W: write cacheline.
REQ-010 SHALL have port out_valid  out  1: out_data holds the head entry.
REQ-011 SHALL have port out_ready  in  1: consumer accepts the head.
REQ-012 SHALL have port out_data  out  DATA_W: head cacheline, driven from a register.
REQ-013 SHALL have port count  out  $clog2(DEPTH)+1: entries held.
REQ-014 SHALL have port almost_full  out  1: present only under CACHELINE_FIFO_AF_EN.

Function
REQ-015 SHALL perform a push when in_valid && in_ready, and a pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count < DEPTH), registered; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-018 SHALL be show-ahead: a push at edge N into an empty FIFO SHALL give out_valid=1 with that data after edge N+2 (1-cycle RAM read plus output register).
REQ-019 SHALL prefetch after a pop: with more entries held, out_valid SHALL stay 1 and the next entry SHALL appear after the same edge. Back-to-back pops SHALL sustain one pop per cycle.
REQ-020 SHALL count every entry held in the RAM, in flight through the read stage, or in the output register. Per edge: count += push - pop.
REQ-021 SHALL wrap the write and read pointers modulo DEPTH with no gap.
REQ-022 SHALL read RAM entries only if they were written at least one edge earlier; a read and a write to the same address in one cycle SHALL never occur.
REQ-023 SHALL, when full, ignore a push in a cycle that also pops (in_ready is already 0); count goes to DEPTH-1.
REQ-024 SHALL NOT change count or the pointers for in_valid while in_ready=0, or for out_ready while out_valid=0.
REQ-025 SHALL preserve data order exactly (FIFO), bit-exact across bank slices.

Reset
REQ-026 SHALL, with reset=1 at an edge, set count=0, pointers=0, out_valid=0, out_data=0, almost_full=0, in_ready=1 after that edge.
REQ-027 SHALL let reset mid-operation discard all held and in-flight entries; RAM contents are not cleared and SHALL never be observable afterwards.

Configuration
REQ-028 SHALL, with macro CACHELINE_FIFO_AF_EN defined, provide almost_full = (count >= AF_THRESH), registered and updated on the same edge as count.
REQ-029 SHALL, without CACHELINE_FIFO_AF_EN, omit the almost_full port and its logic; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL place CL_WIDTH=512 and typedef cacheline_t (logic [CL_WIDTH-1:0]) in shared package cl_pkg; DATA_W defaults to cl_pkg::CL_WIDTH.
REQ-031 SHALL instantiate BANKS copies of sub-module cl_ram_bank. Each is a simple dual-port RAM of width DATA_W/BANKS and depth DEPTH, with a registered 1-cycle read, sharing the write/read address and write enable.

Verification
REQ-032 SHALL cover: reset, then push 0xA5..A5 at edge 1 -> out_valid=1 with out_data=0xA5..A5 after edge 3; count=1.
REQ-033 SHALL cover: push 256 distinct values with out_ready=0 -> in_ready=0 after the 256th push; count=256; a 257th in_valid is dropped.
REQ-034 SHALL cover: full FIFO, in_valid=1 and out_ready=1 for one cycle -> count=255; the head pops and no push occurs.
REQ-035 SHALL cover: continuous push and pop of 1000 words, DEPTH=16 -> in-order data, pointers wrapped more than 60 times, steady one pop per cycle.
REQ-036 SHALL cover: reset asserted with count=37 and out_valid=1 -> after the edge, count=0, out_valid=0, in_ready=1; the next push returns new data only.
REQ-037 SHALL cover: CACHELINE_FIFO_AF_EN, AF_THRESH=248 -> almost_full rises on the edge count reaches 248 and falls on the edge it reaches 247.

Source files
------------

// File: rtl/cl_pkg.sv
// cl_pkg: shared cacheline width and type for the cacheline datapath.
package cl_pkg;

   localparam int CL_WIDTH = 512;

   typedef logic [CL_WIDTH-1:0] cacheline_t;

endpackage

// File: rtl/cl_ram_bank.sv
// cl_ram_bank: simple dual-port RAM slice, one write port and one registered read port.
module cl_ram_bank
   import cl_pkg::*;
#(
   parameter int WIDTH = CL_WIDTH / 2,
   parameter int DEPTH = 256,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: storage and read register carry no reset so this maps onto block RAM;
   // sequential state is always written with <= so all flops sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      // rd_data holds its value when rd_en is low; the FIFO relies on this as a stall buffer.
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cacheline_fifo.sv
// cacheline_fifo: show-ahead FIFO of cachelines over banked 1-cycle-read RAM with a registered head.
// Define CACHELINE_FIFO_AF_EN to add the registered almost_full output.
module cacheline_fifo
   import cl_pkg::*;
#(
   parameter int DATA_W    = CL_WIDTH,
   parameter int DEPTH     = 256,
   parameter int BANKS     = 2,
   parameter int AF_THRESH = DEPTH - 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [$clog2(DEPTH):0] count
`ifdef CACHELINE_FIFO_AF_EN
   ,
   output logic                   almost_full
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = DATA_W / BANKS;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

   if (DATA_W % BANKS != 0) begin : g_bad_banks
      $error("DATA_W must split evenly across BANKS");
   end

   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     ram_count, ram_count_next, count_next;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              push, pop, out_load, rd_en;

   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign out_load = rd_valid && (!out_valid || out_ready);
   // Only entries written on an earlier edge are counted in ram_count, so a read never races a write.
   assign rd_en    = (ram_count != '0) && (!rd_valid || out_load);

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      cl_ram_bank #(
         .WIDTH (BW),
         .DEPTH (DEPTH)
      ) u_bank (
         .clk     (clk),
         .wr_en   (push),
         .wr_addr (wr_ptr),
         .wr_data (in_data[b*BW +: BW]),
         .rd_en   (rd_en),
         .rd_addr (rd_ptr),
         .rd_data (rd_data[b*BW +: BW])
      );
   end

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      count_next     = count;
      ram_count_next = ram_count;
      if (push && !pop)      count_next = count + CW'(1);
      else if (!push && pop) count_next = count - CW'(1);
      if (push && !rd_en)      ram_count_next = ram_count + CW'(1);
      else if (!push && rd_en) ram_count_next = ram_count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
         rd_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
      end else begin
         if (push)  wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         ram_count <= ram_count_next;

         if (rd_en)         rd_valid <= 1'b1;
         else if (out_load) rd_valid <= 1'b0;

         if (out_load) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
         end else if (pop) begin
            out_valid <= 1'b0;
         end

         count    <= count_next;
         in_ready <= (count_next < FULL_LVL);
      end
   end

`ifdef CACHELINE_FIFO_AF_EN
   localparam logic [CW-1:0] AF_LVL = CW'(AF_THRESH);

   always_ff @(posedge clk) begin
      if (reset) almost_full <= 1'b0;
      else       almost_full <= (count_next >= AF_LVL);
   end
`endif

endmodule

// File: tb/tb_cacheline_fifo.sv
// tb_cacheline_fifo: scoreboard bench for cacheline_fifo (DEPTH=256 instance and DEPTH=16 streaming instance).
`timescale 1ns/1ps
module tb_cacheline_fifo;
   import cl_pkg::*;

   localparam int DA = 256;
   localparam int DB = 16;
   localparam int NSTREAM = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   cacheline_t a_in_data, a_out_data;
   logic [8:0] a_count;
   logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   cacheline_t b_in_data, b_out_data;
   logic [4:0] b_count;
`ifdef CACHELINE_FIFO_AF_EN
   logic a_af, b_af;
`endif

   cacheline_fifo #(.DATA_W(CL_WIDTH), .DEPTH(DA), .BANKS(2), .AF_THRESH(248)) u_dut_a (
      .clk(clk), .reset(reset),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .count(a_count)
`ifdef CACHELINE_FIFO_AF_EN
      , .almost_full(a_af)
`endif
   );

   cacheline_fifo #(.DATA_W(CL_WIDTH), .DEPTH(DB), .BANKS(2), .AF_THRESH(DB - 8)) u_dut_b (
      .clk(clk), .reset(reset),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .count(b_count)
`ifdef CACHELINE_FIFO_AF_EN
      , .almost_full(b_af)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input cacheline_t got, input cacheline_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic cacheline_t word(input int i);
      cacheline_t w;
      for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'(i * 16 + k) ^ 32'hC3A5_0000;
      return w;
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboards: the bench decides acceptance from its own occupancy model.
   cacheline_t a_q[$], b_q[$];
   int a_mcnt = 0, b_mcnt = 0;
   logic a_push_ok, b_push_ok;
   int b_sent = 0, b_recv = 0, b_first = 0, b_last = 0;

   always @(negedge clk) begin
      if (reset) begin
         a_q.delete();
         a_mcnt = 0;
      end else begin
         check("a_count", cacheline_t'(a_count), cacheline_t'(a_mcnt));
         check("a_in_ready", cacheline_t'(a_in_ready), cacheline_t'(a_mcnt < DA));
         a_push_ok = a_in_valid && (a_mcnt < DA);
         if (a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) check("a_underflow", 1, 0);
            else check("a_data", a_out_data, a_q.pop_front());
            a_mcnt--;
         end
         if (a_push_ok) begin
            a_q.push_back(a_in_data);
            a_mcnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         b_q.delete();
         b_mcnt = 0;
      end else begin
         check("b_count", cacheline_t'(b_count), cacheline_t'(b_mcnt));
         check("b_in_ready", cacheline_t'(b_in_ready), cacheline_t'(b_mcnt < DB));
         b_push_ok = b_in_valid && (b_mcnt < DB);
         if (b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) check("b_underflow", 1, 0);
            else check("b_data", b_out_data, b_q.pop_front());
            b_mcnt--;
            b_recv++;
            if (b_recv == 1) b_first = cyc;
            b_last = cyc;
         end
         if (b_push_ok) begin
            b_q.push_back(b_in_data);
            b_mcnt++;
            b_sent++;
         end
      end
   end

   task automatic drain_a();
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      for (int k = 0; k < 600 && (a_count != 0 || a_out_valid); k++) step();
      a_out_ready = 1'b0;
      check("a_drain_count", cacheline_t'(a_count), 0);
      check("a_drain_sb", cacheline_t'(a_q.size()), 0);
   endtask

   initial begin
      reset = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
      step(2);
      reset = 1'b0;
      check("rst_count", cacheline_t'(a_count), 0);
      check("rst_out_valid", cacheline_t'(a_out_valid), 0);
      check("rst_in_ready", cacheline_t'(a_in_ready), 1);
      check("rst_out_data", a_out_data, 0);

      // Single push into empty FIFO: head visible two edges later.
      a_in_valid = 1'b1;
      a_in_data  = {64{8'hA5}};
      step();
      a_in_valid = 1'b0;
      check("lat_e1_valid", cacheline_t'(a_out_valid), 0);
      step();
      check("lat_e2_valid", cacheline_t'(a_out_valid), 0);
      step();
      check("lat_e3_valid", cacheline_t'(a_out_valid), 1);
      check("lat_e3_data", a_out_data, {64{8'hA5}});
      check("lat_e3_count", cacheline_t'(a_count), 1);
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      check("pop1_valid", cacheline_t'(a_out_valid), 0);

      // Fill to full with the consumer stalled.
      for (int i = 0; i < DA; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = word(i);
         step();
         if (i == DA - 2) check("fill_ready_255", cacheline_t'(a_in_ready), 1);
      end
      check("full_ready", cacheline_t'(a_in_ready), 0);
      check("full_count", cacheline_t'(a_count), DA);
      a_in_data = word(999);
      step();
      a_in_valid = 1'b0;
      check("drop_257_count", cacheline_t'(a_count), DA);
      check("stall_head", a_out_data, word(0));

      // Full, push and pop together: only the pop happens.
      a_in_valid  = 1'b1;
      a_in_data   = word(777);
      a_out_ready = 1'b1;
      step();
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      check("fullpop_count", cacheline_t'(a_count), DA - 1);
      check("fullpop_ready", cacheline_t'(a_in_ready), 1);
      check("fullpop_next", a_out_data, word(1));
      drain_a();

      // Reset with entries in flight discards them.
      for (int i = 0; i < 37; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = word(2000 + i);
         step();
      end
      a_in_valid = 1'b0;
      step(3);
      check("pre_rst_count", cacheline_t'(a_count), 37);
      check("pre_rst_valid", cacheline_t'(a_out_valid), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_count", cacheline_t'(a_count), 0);
      check("mid_rst_valid", cacheline_t'(a_out_valid), 0);
      check("mid_rst_ready", cacheline_t'(a_in_ready), 1);
      step(4);
      check("no_stale_valid", cacheline_t'(a_out_valid), 0);
      a_in_valid = 1'b1;
      a_in_data  = word(5000);
      step();
      a_in_valid = 1'b0;
      step(2);
      check("post_rst_data", a_out_data, word(5000));
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      check("post_rst_count", cacheline_t'(a_count), 0);

`ifdef CACHELINE_FIFO_AF_EN
      for (int i = 0; i < 247; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = word(6000 + i);
         step();
      end
      check("af_247", cacheline_t'(a_af), 0);
      a_in_data = word(6247);
      step();
      a_in_valid = 1'b0;
      check("af_248", cacheline_t'(a_af), 1);
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      check("af_back_247", cacheline_t'(a_af), 0);
      drain_a();
`endif

      // Continuous streaming through the DEPTH=16 instance.
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = word(100000);
      for (int k = 0; k < 3000 && b_recv < NSTREAM; k++) begin
         step();
         if (b_sent < NSTREAM) begin
            b_in_valid = 1'b1;
            b_in_data  = word(100000 + b_sent);
         end else begin
            b_in_valid = 1'b0;
         end
      end
      b_in_valid = 1'b0;
      check("stream_recv", cacheline_t'(b_recv), NSTREAM);
      check("stream_rate", cacheline_t'(b_last - b_first), NSTREAM - 1);
      step(2);
      check("stream_count", cacheline_t'(b_count), 0);
      check("stream_sb", cacheline_t'(b_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
